// File: rtl/dav_rfd_receiver_pkg.sv
// Shared definitions for the dav_/rfd byte receiver and its producer.
package dav_rfd_receiver_pkg;

   // Byte width of the handshake data path (shared with the producer side).
   localparam int DATA_W = 8;

   // Handshake FSM encoding: R_WAIT = 0 (rfd high), R_ACK = 1 (rfd low).
   typedef enum logic {
      R_WAIT = 1'b0,
      R_ACK  = 1'b1
   } rx_state_e;

endpackage : dav_rfd_receiver_pkg

// File: rtl/dav_rfd_receiver_if.sv
// dav_/rfd producer handshake plus the downstream valid/pop read port.
interface dav_rfd_receiver_if
   import dav_rfd_receiver_pkg::*;
   ();

   logic              dav_;       // producer data-available, active low
   logic [DATA_W-1:0] y;          // producer data, stable while dav_=0
   logic              rfd;        // ready-for-data back to producer
   logic              out_valid;  // FIFO non-empty
   logic [DATA_W-1:0] out_data;   // FIFO head entry
   logic              out_pop;    // consume the head entry

   // Environment side: drives the producer handshake and the pop request.
   modport master (
      output dav_, y, out_pop,
      input  rfd, out_valid, out_data
   );

   // Receiver side.
   modport slave (
      input  dav_, y, out_pop,
      output rfd, out_valid, out_data
   );

endinterface : dav_rfd_receiver_if

// File: rtl/dav_rfd_receiver_byte_fifo.sv
// First-word-fall-through byte FIFO: circular buffer with read/write
// pointers and an occupancy counter. Pushes while full and pops while
// empty are ignored. The head reads 0 whenever the FIFO is empty.
module byte_fifo
   import dav_rfd_receiver_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DATA_W-1:0]      push_data,
   input  logic                   pop,
   output logic [DATA_W-1:0]      head,
   output logic                   valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign valid   = (count != '0);
   assign full    = (count == FULL_CNT);
   assign level   = count;
   assign do_push = push && !full;
   assign do_pop  = pop && valid;
   assign head    = valid ? mem[rd_ptr] : '0;

   // Storage write at the tail.
   // NOTE: the storage array is deliberately not reset; emptiness is tracked by count and head is masked to 0 when empty.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule : byte_fifo

// File: rtl/dav_rfd_receiver.sv
// Consumer end of the dav_/rfd byte handshake. Captures one byte per dav_
// low phase into a FWFT FIFO, holds rfd high (no capture) while the FIFO
// is full, and keeps a byte count and running maximum.
module dav_rfd_receiver
   import dav_rfd_receiver_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   dav_rfd_receiver_if.slave      bus,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level,
   input  logic                   stat_clr,
   output logic [CNT_W-1:0]       rx_count,
   output logic [DATA_W-1:0]      rx_max
);

   rx_state_e state;
   logic      rfd_q;
   logic      push;

   // Capture only in R_WAIT, on dav_ low, judged against the pre-edge full flag.
   assign push    = (state == R_WAIT) && !bus.dav_ && !full;
   assign bus.rfd = rfd_q;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (bus.y),
      .pop       (bus.out_pop),
      .head      (bus.out_data),
      .valid     (bus.out_valid),
      .full      (full),
      .level     (level)
   );

   // Handshake FSM with registered rfd: one capture per dav_ low phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= R_WAIT;
         rfd_q <= 1'b1;
      end else begin
         case (state)
            R_WAIT: begin
               if (push) begin
                  state <= R_ACK;
                  rfd_q <= 1'b0;
               end
            end
            R_ACK: begin
               if (bus.dav_) begin
                  state <= R_WAIT;
                  rfd_q <= 1'b1;
               end
            end
            default: begin
               state <= R_WAIT;
               rfd_q <= 1'b1;
            end
         endcase
      end
   end

   // Receive statistics; a clear coinciding with a push restarts from that byte.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_count <= '0;
         rx_max   <= '0;
      end else if (push) begin
         rx_count <= stat_clr ? CNT_W'(1) : rx_count + 1'b1;
         rx_max   <= (stat_clr || (bus.y > rx_max)) ? bus.y : rx_max;
      end else if (stat_clr) begin
         rx_count <= '0;
         rx_max   <= '0;
      end
   end

endmodule : dav_rfd_receiver

// File: tb/tb_dav_rfd_receiver.sv
// Directed bench for dav_rfd_receiver: a vector table for the basic
// handshake / fill / drain flow, then hand-written statistics-clear and
// mid-handshake reset sequences.
module tb_dav_rfd_receiver;

   logic        clock = 1'b0;
   logic        reset;
   logic        stat_clr;
   logic        full;
   logic [2:0]  level;
   logic [15:0] rx_count;
   logic [7:0]  rx_max;

   int total = 0;
   int bad   = 0;

   dav_rfd_receiver_if bus ();

   dav_rfd_receiver #(.DEPTH(4), .CNT_W(16)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus.slave),
      .full     (full),
      .level    (level),
      .stat_clr (stat_clr),
      .rx_count (rx_count),
      .rx_max   (rx_max)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst, dav, pop, clr;
      logic [7:0]  y;
      logic        rfd, valid, full;
      logic [7:0]  data;
      logic [2:0]  level;
      logic [15:0] cnt;
      logic [7:0]  max;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, dav, pop, clr, input logic [7:0] y,
                      input logic rfd, valid, fl, input logic [7:0] data,
                      input logic [2:0] lvl, input logic [15:0] cnt, input logic [7:0] mx);
      vec_t v;
      v.rst = rst; v.dav = dav; v.pop = pop; v.clr = clr; v.y = y;
      v.rfd = rfd; v.valid = valid; v.full = fl; v.data = data;
      v.level = lvl; v.cnt = cnt; v.max = mx;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic rfd, valid, fl,
                            input logic [7:0] data, input logic [2:0] lvl,
                            input logic [15:0] cnt, input logic [7:0] mx);
      check({tag, ".rfd"},       32'(bus.rfd),       32'(rfd));
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(valid));
      check({tag, ".full"},      32'(full),          32'(fl));
      check({tag, ".out_data"},  32'(bus.out_data),  32'(data));
      check({tag, ".level"},     32'(level),         32'(lvl));
      check({tag, ".rx_count"},  32'(rx_count),      32'(cnt));
      check({tag, ".rx_max"},    32'(rx_max),        32'(mx));
   endtask

   // One full dav_ low/high phase; optionally pop during the high phase.
   task automatic send_byte(input logic [7:0] b, input logic pop_on_release);
      bus.dav_ = 1'b0; bus.y = b; bus.out_pop = 1'b0;
      step();
      bus.dav_ = 1'b1; bus.out_pop = pop_on_release;
      step();
      bus.out_pop = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stat_clr = 1'b0;
      bus.dav_ = 1'b1; bus.y = 8'h00; bus.out_pop = 1'b0;

      //   rst dav pop clr  y      | rfd vld full data  lvl cnt max
      add(1, 1, 0, 0, 8'h00,   1, 0, 0, 8'h00, 0, 0, 8'h00);   // reset
      add(0, 0, 0, 0, 8'h5A,   0, 1, 0, 8'h5A, 1, 1, 8'h5A);   // capture 0x5A
      add(0, 0, 0, 0, 8'h5A,   0, 1, 0, 8'h5A, 1, 1, 8'h5A);   // held low: no re-capture
      add(0, 0, 0, 0, 8'h5A,   0, 1, 0, 8'h5A, 1, 1, 8'h5A);
      add(0, 1, 0, 0, 8'h00,   1, 1, 0, 8'h5A, 1, 1, 8'h5A);   // release
      add(0, 1, 1, 0, 8'h00,   1, 0, 0, 8'h00, 0, 1, 8'h5A);   // pop 0x5A
      add(0, 0, 0, 0, 8'h10,   0, 1, 0, 8'h10, 1, 2, 8'h5A);
      add(0, 1, 0, 0, 8'h10,   1, 1, 0, 8'h10, 1, 2, 8'h5A);
      add(0, 0, 0, 0, 8'h80,   0, 1, 0, 8'h10, 2, 3, 8'h80);
      add(0, 1, 0, 0, 8'h80,   1, 1, 0, 8'h10, 2, 3, 8'h80);
      add(0, 0, 0, 0, 8'h7F,   0, 1, 0, 8'h10, 3, 4, 8'h80);
      add(0, 1, 0, 0, 8'h7F,   1, 1, 0, 8'h10, 3, 4, 8'h80);
      add(0, 0, 0, 0, 8'hFF,   0, 1, 1, 8'h10, 4, 5, 8'hFF);   // now full
      add(0, 1, 0, 0, 8'hFF,   1, 1, 1, 8'h10, 4, 5, 8'hFF);
      add(0, 0, 0, 0, 8'h01,   1, 1, 1, 8'h10, 4, 5, 8'hFF);   // full: rfd held, no capture
      add(0, 0, 0, 0, 8'h01,   1, 1, 1, 8'h10, 4, 5, 8'hFF);
      add(0, 0, 1, 0, 8'h01,   1, 1, 0, 8'h80, 3, 5, 8'hFF);   // pop while full: no capture
      add(0, 0, 0, 0, 8'h01,   0, 1, 1, 8'h80, 4, 6, 8'hFF);   // capture next edge
      add(0, 1, 0, 0, 8'h00,   1, 1, 1, 8'h80, 4, 6, 8'hFF);
      add(0, 1, 1, 0, 8'h00,   1, 1, 0, 8'h7F, 3, 6, 8'hFF);   // drain
      add(0, 1, 1, 0, 8'h00,   1, 1, 0, 8'hFF, 2, 6, 8'hFF);
      add(0, 1, 1, 0, 8'h00,   1, 1, 0, 8'h01, 1, 6, 8'hFF);
      add(0, 1, 1, 0, 8'h00,   1, 0, 0, 8'h00, 0, 6, 8'hFF);
      add(0, 1, 1, 0, 8'h00,   1, 0, 0, 8'h00, 0, 6, 8'hFF);   // pop on empty ignored
      add(0, 0, 0, 0, 8'h42,   0, 1, 0, 8'h42, 1, 7, 8'hFF);   // next push at head
      add(0, 1, 1, 0, 8'h00,   1, 0, 0, 8'h00, 0, 7, 8'hFF);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; stat_clr = vecs[i].clr;
         bus.dav_ = vecs[i].dav; bus.y = vecs[i].y; bus.out_pop = vecs[i].pop;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].rfd, vecs[i].valid, vecs[i].full,
                   vecs[i].data, vecs[i].level, vecs[i].cnt, vecs[i].max);
      end

      // Statistics clear coinciding with a push.
      reset = 1'b1; bus.dav_ = 1'b1; bus.out_pop = 1'b0;
      step();
      reset = 1'b0;
      send_byte(8'h20, 1'b1);
      send_byte(8'h40, 1'b1);
      send_byte(8'h60, 1'b1);
      send_byte(8'h30, 1'b1);
      send_byte(8'h10, 1'b1);
      check_all("pre_clr", 1, 0, 0, 8'h00, 0, 5, 8'h60);
      bus.dav_ = 1'b0; bus.y = 8'h33; stat_clr = 1'b1;
      step();
      check_all("clr_push", 0, 1, 0, 8'h33, 1, 1, 8'h33);
      stat_clr = 1'b0; bus.dav_ = 1'b1; bus.out_pop = 1'b1;
      step();
      bus.out_pop = 1'b0; stat_clr = 1'b1;
      step();
      check_all("clr_only", 1, 0, 0, 8'h00, 0, 0, 8'h00);
      stat_clr = 1'b0;

      // Reset while in R_ACK with two entries stored.
      send_byte(8'h11, 1'b0);
      bus.dav_ = 1'b0; bus.y = 8'h22;
      step();
      check_all("in_ack", 0, 1, 0, 8'h11, 2, 2, 8'h22);
      reset = 1'b1;
      step();
      check_all("ack_reset", 1, 0, 0, 8'h00, 0, 0, 8'h00);
      reset = 1'b0; bus.dav_ = 1'b1;
      step();
      check_all("post_rst_idle", 1, 0, 0, 8'h00, 0, 0, 8'h00);
      bus.dav_ = 1'b0; bus.y = 8'h99;
      step();
      check_all("post_rst_cap", 0, 1, 0, 8'h99, 1, 1, 8'h99);
      bus.dav_ = 1'b1;
      step();
      check_all("post_rst_rel", 1, 1, 0, 8'h99, 1, 1, 8'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dav_rfd_receiver

// File: doc/dav_rfd_receiver.md
Name: dav_rfd_receiver

Overview:
- Consumer end of the dav_/rfd byte handshake driven by the team's ADC/EPROM filter producer.
- Accepts each 8-bit value the producer presents and buffers it in a small first-word-fall-through FIFO.
- Exposes the buffered values to downstream logic through a valid/pop interface.
- Keeps simple receive statistics: a byte count and a running maximum.
- Applies backpressure to the producer by holding rfd when the FIFO is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the received-byte counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dav_  in  1  producer data-available, active low.
- y  in  8  producer data; stable while dav_=0.
- rfd  out  1  ready-for-data to the producer, active high.
- out_valid  out  1  FIFO non-empty.
- out_data  out  8  FIFO head entry; valid when out_valid=1.
- out_pop  in  1  consume the head entry this cycle.
- full  out  1  FIFO occupancy = DEPTH.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- stat_clr  in  1  clear the statistics.
- rx_count  out  CNT_W  bytes accepted since reset or clear; wraps modulo 2^CNT_W.
- rx_max  out  8  largest byte accepted since reset or clear, unsigned.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=R_WAIT, rfd=1, FIFO emptied (level=0, out_valid=0, full=0).
  - out_data=0, rx_count=0, rx_max=0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-handshake (in R_ACK) returns to R_WAIT with rfd=1; the byte already captured is discarded with the FIFO.
- Handshake FSM, two states, rfd registered:
  - R_WAIT (rfd=1):
    - If dav_=0 and the FIFO is not full at this edge: write y into the FIFO tail, rfd<=0, go to R_ACK.
    - If dav_=0 and the FIFO is full: stay in R_WAIT with rfd=1. The producer holds y and dav_ low until space frees.
    - If dav_=1: stay.
  - R_ACK (rfd=0):
    - If dav_=1: rfd<=1, go to R_WAIT.
    - Otherwise stay. No capture occurs in R_ACK, so each dav_ low phase yields exactly one byte.
- Latency:
  - dav_ sampled low at edge N (space available): rfd=0, out_valid=1 (if previously empty) and level incremented, all visible after edge N.
  - dav_ sampled high at edge M in R_ACK: rfd=1 after edge M.
  - Minimum of 2 clocks per byte.
- FIFO:
  - Circular buffer with a read pointer, a write pointer and an occupancy counter.
  - Pointers wrap modulo DEPTH.
  - out_data always shows the head entry; it reads 0 when the FIFO is empty.
  - out_pop with out_valid=1: head advances and level decrements at the edge.
  - out_pop while empty: ignored.
- Push and pop in the same cycle:
  - Push eligibility uses the pre-edge full flag; a pop in the same cycle does not enable a push from a full FIFO.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves level unchanged.
  - Simultaneous push and pop on an empty FIFO is impossible because the pop is ignored; the push occurs and level becomes 1.
- Statistics:
  - On each push: rx_count+1 (wrapping), rx_max=max(rx_max, y).
  - stat_clr=1 without a push: rx_count<=0, rx_max<=0.
  - stat_clr=1 together with a push: rx_count<=1, rx_max<=y.
  - Statistics are independent of pops.

Decomposition:
- Shared package holds:
  - the state encoding localparams R_WAIT=0 and R_ACK=1;
  - the data width constant DATA_W=8, reused by the producer.
- One natural sub-module: byte_fifo (parameter DEPTH; ports push, push_data, pop, head, valid, full, level).
- The top level holds the FSM and the statistics.

Test Plan:
- Reset, then a single byte 0x5A with dav_ low for 3 cycles:
  - rfd falls the cycle after the first sample and stays 0 until dav_ returns high;
  - exactly one entry; out_data=0x5A; rx_count=1; rx_max=0x5A.
- Push 0x10, 0x80, 0x7F, 0xFF, 0x01 with out_pop=0 and DEPTH=4:
  - after the 4th byte, full=1;
  - the 5th dav_ low holds rfd=1 with no capture;
  - a pop of 0x10 lets 0x01 be captured the next edge;
  - drain order is 0x80, 0x7F, 0xFF, 0x01; rx_max=0xFF.
- FIFO full with dav_ low and out_pop=1 in the same cycle:
  - level goes 4→3 and no capture that cycle;
  - capture happens the following edge, level back to 4.
- Pop on an empty FIFO: level stays 0 and pointers are unchanged, checked by the next push appearing at out_data.
- stat_clr asserted in the same cycle as a push of 0x33 after rx_count=5: rx_count=1, rx_max=0x33.
- Reset asserted while in R_ACK with 2 entries stored:
  - next cycle rfd=1, level=0, rx_count=0;
  - a subsequent dav_ high/low cycle captures normally.
